// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle RV32I controller.
//   state_t        controller FSM states
//   OP_*           RV32I major opcodes recognised by the controller
//   SRC_A_*/SRC_B_*/ALU_*/IMM_*/RES_*  datapath select encodings, shared
//                  with the datapath so both sides agree on mux ordering
//   decode_next()  DECODE-state dispatch from opcode to the first execute state
package mc_pkg;

  typedef enum logic [4:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    LUI,
    AUIPC,
    ALU_WB,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    BRANCH,
    JAL,
    JALR,
    JALR_PC,
    LINK,
    TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_R:                decode_next = EXEC_R;
      OP_IMM:              decode_next = EXEC_I;
      OP_LOAD, OP_STORE:   decode_next = MEM_ADDR;
      OP_BRANCH:           decode_next = BRANCH;
      OP_JAL:              decode_next = JAL;
      OP_JALR:             decode_next = JALR;
      OP_LUI:              decode_next = LUI;
      OP_AUIPC:            decode_next = AUIPC;
      default:             decode_next = TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: combinational state-to-control decode.
//   state         current controller state
//   opcode        instruction register opcode (selects imm format in DECODE/MEM_ADDR)
//   mem_ready     memory handshake; only looked at in states issuing mem_req
//   branch_taken  comparator result, only looked at in BRANCH
//   outputs       datapath selects, ALU op class, immediate format, enables, retire
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       retire
);

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    alu_op     = '0;
    imm_src    = '0;
    result_src = '0;
    retire     = 1'b0;

    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALU;
        // Instruction and PC+4 are captured only in the cycle memory completes.
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        // Branch/jump target is precomputed here into alu_out.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_I;
        alu_op    = ALU_FUNCT;
      end
      LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_U;
      end
      AUIPC: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_U;
      end
      ALU_WB, LINK: begin
        reg_write  = 1'b1;
        result_src = RES_ALU_OUT;
        retire     = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        retire  = mem_ready;
      end
      BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_SUB;
        result_src = RES_ALU_OUT;
        pc_write   = branch_taken;
        retire     = 1'b1;
      end
      JAL, JALR_PC: begin
        // PC takes the target from alu_out while the ALU forms old_pc+4 for the link.
        pc_write   = 1'b1;
        result_src = RES_ALU_OUT;
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
      end
      JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_I;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a shared-ALU, single-memory RV32I
// multicycle datapath (fetch, decode, execute, memory, writeback).
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   opcode, func3 instruction register fields
//   branch_taken  comparator result for the current branch
//   mem_ready     memory completes the current request this cycle
//   mem_req/mem_we/adr_src           memory request controls
//   ir_write/pc_write/reg_write      state-element write enables
//   alu_src_a/alu_src_b/alu_op/imm_src/result_src  datapath selects
//   retire        pulse in the final cycle of each instruction
//   illegal       sticky unsupported-opcode flag, cleared only by reset
module multicycle_controller
  import mc_pkg::*;
#(
  parameter bit RESET_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       illegal
);

  localparam state_t RESET_STATE = RESET_IDLE ? IDLE : FETCH;

  state_t state_q;
  state_t state_n;
  logic   illegal_q;

  // func3 is carried for datapath-side width/sign selection; sequencing never needs it.
  logic unused_func3;
  assign unused_func3 = ^func3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_n == TRAP)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:      state_n = FETCH;
      FETCH:     if (mem_ready) state_n = DECODE;
      DECODE:    state_n = decode_next(opcode);
      EXEC_R,
      EXEC_I,
      LUI,
      AUIPC:     state_n = ALU_WB;
      ALU_WB:    state_n = FETCH;
      MEM_ADDR:  state_n = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) state_n = MEM_WB;
      MEM_WB:    state_n = FETCH;
      MEM_WRITE: if (mem_ready) state_n = FETCH;
      BRANCH:    state_n = FETCH;
      JAL:       state_n = LINK;
      JALR:      state_n = JALR_PC;
      JALR_PC:   state_n = LINK;
      LINK:      state_n = FETCH;
      TRAP:      state_n = TRAP;
      default:   state_n = RESET_STATE;
    endcase
  end

  assign illegal = illegal_q;

  mc_output_decode u_decode (
    .state        (state_q),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_src      (imm_src),
    .result_src   (result_src),
    .retire       (retire)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle stimulus with a scoreboard of
// expected control vectors; a negedge monitor pops and compares each cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       retire, illegal;

  always #5 clk = ~clk;

  multicycle_controller #(.RESET_IDLE(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .func3        (func3),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_src      (imm_src),
    .result_src   (result_src),
    .retire       (retire),
    .illegal      (illegal)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [2:0] imm;
    logic [1:0] res;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  typedef enum {
    E_IDLE, E_FETCH, E_DECODE, E_DECODE_J, E_EXEC_R, E_EXEC_I, E_LUI, E_AUIPC,
    E_ALU_WB, E_MEM_ADDR_L, E_MEM_ADDR_S, E_MEM_READ, E_MEM_WB, E_MEM_WRITE,
    E_BRANCH, E_JAL, E_JALR, E_JALR_PC, E_LINK, E_TRAP
  } es_t;

  typedef struct {
    ctrl_t c;
    string tag;
  } exp_e;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] LUI_OP = 7'b0110111;
  localparam logic [6:0] AUI_OP = 7'b0010111;

  exp_e sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  // Hand-written control vector for each state; m is the cycle's
  // handshake-dependent bit (mem_ready fire or branch_taken).
  function automatic ctrl_t ex(input es_t s, input bit m);
    ctrl_t c;
    c = '0;
    case (s)
      E_FETCH:      begin c.mem_req = 1; c.b = 2'b10; c.res = 2'b10; c.ir_write = m; c.pc_write = m; end
      E_DECODE:     begin c.a = 2'b01; c.b = 2'b01; c.imm = 3'b010; end
      E_DECODE_J:   begin c.a = 2'b01; c.b = 2'b01; c.imm = 3'b100; end
      E_EXEC_R:     begin c.a = 2'b10; c.b = 2'b00; c.op = 2'b10; end
      E_EXEC_I:     begin c.a = 2'b10; c.b = 2'b01; c.op = 2'b10; end
      E_LUI:        begin c.a = 2'b11; c.b = 2'b01; c.imm = 3'b011; end
      E_AUIPC:      begin c.a = 2'b01; c.b = 2'b01; c.imm = 3'b011; end
      E_ALU_WB:     begin c.reg_write = 1; c.retire = 1; end
      E_MEM_ADDR_L: begin c.a = 2'b10; c.b = 2'b01; end
      E_MEM_ADDR_S: begin c.a = 2'b10; c.b = 2'b01; c.imm = 3'b001; end
      E_MEM_READ:   begin c.mem_req = 1; c.adr_src = 1; end
      E_MEM_WB:     begin c.reg_write = 1; c.res = 2'b01; c.retire = 1; end
      E_MEM_WRITE:  begin c.mem_req = 1; c.mem_we = 1; c.adr_src = 1; c.retire = m; end
      E_BRANCH:     begin c.a = 2'b10; c.op = 2'b01; c.pc_write = m; c.retire = 1; end
      E_JAL:        begin c.pc_write = 1; c.a = 2'b01; c.b = 2'b10; end
      E_JALR:       begin c.a = 2'b10; c.b = 2'b01; end
      E_JALR_PC:    begin c.pc_write = 1; c.a = 2'b01; c.b = 2'b10; end
      E_LINK:       begin c.reg_write = 1; c.retire = 1; end
      E_TRAP:       begin c.illegal = 1; end
      default:      ;
    endcase
    return c;
  endfunction

  // Apply inputs just after the rising edge and queue what the cycle must show.
  task automatic step(input logic r, input logic [6:0] opc, input logic rdy,
                      input logic bt, input es_t s, input bit m);
    exp_e e;
    @(posedge clk);
    #1;
    rst = r;
    opcode = opc;
    mem_ready = rdy;
    branch_taken = bt;
    e.c = ex(s, m);
    e.tag = s.name();
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_e e;
    ctrl_t act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
             alu_src_b, alu_op, imm_src, result_src, retire, illegal};
      total++;
      if (act !== e.c) begin
        bad++;
        $display("FAIL %s @%0t: got %05h want %05h", e.tag, $time, act, e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // reset state, then R-type with mem_ready tied high
    step(1, R_OP, 1, 0, E_IDLE, 0);
    step(0, R_OP, 1, 0, E_IDLE, 0);
    step(0, R_OP, 1, 0, E_FETCH, 1);
    step(0, R_OP, 1, 0, E_DECODE, 0);
    step(0, R_OP, 1, 0, E_EXEC_R, 0);
    step(0, R_OP, 1, 0, E_ALU_WB, 0);
    // I-type, LUI, AUIPC
    step(0, I_OP, 1, 0, E_FETCH, 1);
    step(0, I_OP, 1, 0, E_DECODE, 0);
    step(0, I_OP, 1, 0, E_EXEC_I, 0);
    step(0, I_OP, 1, 0, E_ALU_WB, 0);
    step(0, LUI_OP, 1, 0, E_FETCH, 1);
    step(0, LUI_OP, 1, 0, E_DECODE, 0);
    step(0, LUI_OP, 1, 0, E_LUI, 0);
    step(0, LUI_OP, 1, 0, E_ALU_WB, 0);
    step(0, AUI_OP, 1, 0, E_FETCH, 1);
    step(0, AUI_OP, 1, 0, E_DECODE, 0);
    step(0, AUI_OP, 1, 0, E_AUIPC, 0);
    step(0, AUI_OP, 1, 0, E_ALU_WB, 0);
    // load with three wait cycles in MEM_READ
    func3 = 3'b010;
    step(0, LD_OP, 1, 0, E_FETCH, 1);
    step(0, LD_OP, 1, 0, E_DECODE, 0);
    step(0, LD_OP, 1, 0, E_MEM_ADDR_L, 0);
    for (int i = 0; i < 3; i++) step(0, LD_OP, 0, 0, E_MEM_READ, 0);
    step(0, LD_OP, 1, 0, E_MEM_READ, 0);
    step(0, LD_OP, 1, 0, E_MEM_WB, 0);
    // store, with a wait in FETCH and in MEM_WRITE
    func3 = 3'b000;
    step(0, ST_OP, 0, 0, E_FETCH, 0);
    step(0, ST_OP, 1, 0, E_FETCH, 1);
    step(0, ST_OP, 1, 0, E_DECODE, 0);
    step(0, ST_OP, 1, 0, E_MEM_ADDR_S, 0);
    step(0, ST_OP, 0, 0, E_MEM_WRITE, 0);
    step(0, ST_OP, 1, 0, E_MEM_WRITE, 1);
    // branch taken, then not taken
    step(0, BR_OP, 1, 1, E_FETCH, 1);
    step(0, BR_OP, 1, 1, E_DECODE, 0);
    step(0, BR_OP, 1, 1, E_BRANCH, 1);
    step(0, BR_OP, 1, 0, E_FETCH, 1);
    step(0, BR_OP, 1, 0, E_DECODE, 0);
    step(0, BR_OP, 1, 0, E_BRANCH, 0);
    // JAL then JALR
    step(0, JAL_OP, 1, 0, E_FETCH, 1);
    step(0, JAL_OP, 1, 0, E_DECODE_J, 0);
    step(0, JAL_OP, 1, 0, E_JAL, 0);
    step(0, JAL_OP, 1, 0, E_LINK, 0);
    step(0, JR_OP, 1, 0, E_FETCH, 1);
    step(0, JR_OP, 1, 0, E_DECODE, 0);
    step(0, JR_OP, 1, 0, E_JALR, 0);
    step(0, JR_OP, 1, 0, E_JALR_PC, 0);
    step(0, JR_OP, 1, 0, E_LINK, 0);
    // unsupported opcode: sticky trap
    step(0, 7'b0000000, 1, 0, E_FETCH, 1);
    step(0, 7'b0000000, 1, 0, E_DECODE, 0);
    for (int i = 0; i < 10; i++) step(0, R_OP, 1, 0, E_TRAP, 0);
    // reset raised between edges must clear TRAP and illegal at once
    step(1, R_OP, 1, 0, E_IDLE, 0);
    step(0, LD_OP, 1, 0, E_IDLE, 0);
    step(0, LD_OP, 1, 0, E_FETCH, 1);
    step(0, LD_OP, 1, 0, E_DECODE, 0);
    step(0, LD_OP, 1, 0, E_MEM_ADDR_L, 0);
    step(0, LD_OP, 0, 0, E_MEM_READ, 0);
    step(0, LD_OP, 0, 0, E_MEM_READ, 0);
    // reset mid-MEM_READ
    step(1, LD_OP, 1, 0, E_IDLE, 0);
    step(0, R_OP, 1, 0, E_IDLE, 0);
    step(0, R_OP, 1, 0, E_FETCH, 1);
    step(0, R_OP, 1, 0, E_DECODE, 0);

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
